// File: rtl/result_display_pkg.sv
// Shared types for the divider result display: FSM states, internal digit codes,
// segment patterns and the double-dabble step.
package result_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV_Q = 2'd1,
        ST_CONV_R = 2'd2,
        ST_LOAD   = 2'd3
    } state_t;

    // Digit codes 0-9 are the decimal values themselves
    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_E     = 4'd11;
    localparam logic [3:0] DIG_R     = 4'd12;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    // Segment order {g,f,e,d,c,b,a}, active-low
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // One double-dabble iteration: correct nibbles >= 5, then shift {bcd, bin} left
    function automatic logic [19:0] dabble_step(input logic [11:0] bcd, input logic [7:0] bin);
        logic [11:0] adj;
        for (int i = 0; i < 3; i++) begin
            adj[i*4 +: 4] = (bcd[i*4 +: 4] >= 4'd5) ? bcd[i*4 +: 4] + 4'd3 : bcd[i*4 +: 4];
        end
        return {adj[10:0], bin, 1'b0};
    endfunction

endpackage

// File: rtl/result_display_if.sv
// Divider-result bus into the display block plus the scanned display outputs.
interface result_display_if;
    logic       done;
    logic       DVZ;
    logic [7:0] quo_mag;
    logic       quo_neg;
    logic [7:0] rem_mag;
    logic       rem_neg;
    logic       sel_rem;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;

    modport master (
        output done, DVZ, quo_mag, quo_neg, rem_mag, rem_neg, sel_rem,
        input  seg, an, busy
    );

    modport slave (
        input  done, DVZ, quo_mag, quo_neg, rem_mag, rem_neg, sel_rem,
        output seg, an, busy
    );
endinterface

// File: rtl/result_display_seg7_encode.sv
// Combinational digit-code to active-low seven-segment pattern; unknown codes are blank.
module seg7_encode
    import result_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:      seg = SEG_0;
            4'd1:      seg = SEG_1;
            4'd2:      seg = SEG_2;
            4'd3:      seg = SEG_3;
            4'd4:      seg = SEG_4;
            4'd5:      seg = SEG_5;
            4'd6:      seg = SEG_6;
            4'd7:      seg = SEG_7;
            4'd8:      seg = SEG_8;
            4'd9:      seg = SEG_9;
            DIG_MINUS: seg = SEG_MINUS;
            DIG_E:     seg = SEG_E;
            DIG_R:     seg = SEG_R;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_display.sv
// Latches signed quotient/remainder on a done edge, converts both to BCD serially and
// scans the selected result (or "Err ") onto a 4-digit multiplexed seven-segment display.
module result_display
    import result_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    result_display_if.slave  bus
);

    state_t      state, state_nxt;
    logic        done_q;
    logic        capture;
    logic        last;
    logic [2:0]  cnt;
    logic [7:0]  wbin;
    logic [11:0] wbcd;
    logic [19:0] step;
    logic [7:0]  rem_mag_l;
    logic        quo_neg_l, rem_neg_l;
    logic [11:0] bcd_q, bcd_r;
    logic [11:0] disp_q, disp_r;
    logic        disp_qn, disp_rn;
    logic        valid;

    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]  idx;
    logic [11:0] sel_bcd;
    logic        sel_neg;
    logic [3:0]  dig;
    logic [6:0]  seg_c;
    logic [6:0]  seg_r;
    logic [3:0]  an_r;

    assign capture = bus.done & ~done_q & ~bus.DVZ;
    assign last    = (cnt == 3'd7);
    assign step    = dabble_step(wbcd, wbin);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // A fresh capture always restarts the sequence, even mid-conversion
    always_comb begin
        state_nxt = state;
        bus.busy  = (state != ST_IDLE);
        if (capture) begin
            state_nxt = ST_CONV_Q;
        end else begin
            case (state)
                ST_CONV_Q: if (last) state_nxt = ST_CONV_R;
                ST_CONV_R: if (last) state_nxt = ST_LOAD;
                ST_LOAD:   state_nxt = ST_IDLE;
                default:   state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            cnt       <= 3'd0;
            wbin      <= 8'd0;
            wbcd      <= 12'd0;
            rem_mag_l <= 8'd0;
            quo_neg_l <= 1'b0;
            rem_neg_l <= 1'b0;
            bcd_q     <= 12'd0;
            bcd_r     <= 12'd0;
            disp_q    <= 12'd0;
            disp_r    <= 12'd0;
            disp_qn   <= 1'b0;
            disp_rn   <= 1'b0;
            valid     <= 1'b0;
        end else begin
            done_q <= bus.done;
            if (capture) begin
                wbin      <= bus.quo_mag;
                wbcd      <= 12'd0;
                rem_mag_l <= bus.rem_mag;
                quo_neg_l <= bus.quo_neg;
                rem_neg_l <= bus.rem_neg;
                cnt       <= 3'd0;
            end else begin
                case (state)
                    ST_CONV_Q: begin
                        cnt <= cnt + 3'd1;
                        if (last) begin
                            bcd_q <= step[19:8];
                            wbin  <= rem_mag_l;
                            wbcd  <= 12'd0;
                        end else begin
                            {wbcd, wbin} <= step;
                        end
                    end
                    ST_CONV_R: begin
                        cnt <= cnt + 3'd1;
                        if (last) bcd_r <= step[19:8];
                        else      {wbcd, wbin} <= step;
                    end
                    ST_LOAD: begin
                        disp_q  <= bcd_q;
                        disp_r  <= bcd_r;
                        disp_qn <= quo_neg_l;
                        disp_rn <= rem_neg_l;
                        valid   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) refresh <= '0;
        else        refresh <= refresh + 1'b1;
    end

    assign idx = refresh[REFRESH_BITS-1 -: 2];

    // Digit mux: error text overrides everything, then the blank pre-capture state
    always_comb begin
        sel_bcd = bus.sel_rem ? disp_r  : disp_q;
        sel_neg = bus.sel_rem ? disp_rn : disp_qn;
        dig     = DIG_BLANK;
        if (bus.DVZ) begin
            case (idx)
                2'd3:    dig = DIG_E;
                2'd2:    dig = DIG_R;
                2'd1:    dig = DIG_R;
                default: dig = DIG_BLANK;
            endcase
        end else if (valid) begin
            case (idx)
                2'd3:    dig = (sel_neg && sel_bcd != 12'd0) ? DIG_MINUS : DIG_BLANK;
                2'd2:    dig = (sel_bcd[11:8] == 4'd0) ? DIG_BLANK : sel_bcd[11:8];
                2'd1:    dig = (sel_bcd[11:4] == 8'd0) ? DIG_BLANK : sel_bcd[7:4];
                default: dig = sel_bcd[3:0];
            endcase
        end
    end

    seg7_encode u_seg7_encode (
        .code (dig),
        .seg  (seg_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seg_r <= SEG_BLANK;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_c;
            an_r  <= ~(4'b0001 << idx);
        end
    end

    assign bus.seg = seg_r;
    assign bus.an  = an_r;

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter REFRESH_BITS, default 17, the width of the refresh counter; the digit advances every 2^(REFRESH_BITS-2) cycles.
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 done  in  1  divider-control idle/finished level.
REQ-005 DVZ  in  1  divider-control divide-by-zero level.
REQ-006 quo_mag  in  8  quotient magnitude; quo_neg  in  1  quotient sign.
REQ-007 rem_mag  in  8  remainder magnitude; rem_neg  in  1  remainder sign.
REQ-008 sel_rem  in  1  0 = show quotient, 1 = show remainder.
REQ-009 seg  out  7  {g,f,e,d,c,b,a}, active-low; an  out  4  digit enables, active-low, an[3] leftmost.
REQ-010 busy  out  1  BCD conversion in progress.

Function
REQ-011 Capture: on a done rising edge (done=1, previous-cycle done=0) with DVZ=0, quo_mag, quo_neg, rem_mag and rem_neg SHALL be latched on that clock edge.
REQ-012 FSM states: IDLE, CONV_Q, CONV_R, LOAD. Capture -> CONV_Q; CONV_Q runs 8 cycles -> CONV_R; CONV_R runs 8 cycles -> LOAD; LOAD runs 1 cycle -> IDLE.
REQ-013 Conversion SHALL be sequential double-dabble: each cycle, add 3 to every 4-bit BCD nibble >= 5, then shift the 12-bit BCD/8-bit binary pair left by 1.
REQ-014 In LOAD, both 12-bit BCD results and both signs SHALL be copied atomically into display registers; the display never shows a partial conversion.
REQ-015 busy SHALL be 1 in CONV_Q, CONV_R and LOAD, and 0 otherwise; display registers update exactly 17 cycles after the capture edge.
REQ-016 A capture edge while busy=1 SHALL relatch the operands and restart at CONV_Q with count 0 (latest wins).
REQ-017 Digit content from the selected operand: digit3 = '-' if sign=1 and magnitude != 0, else blank; digits 2..0 = hundreds, tens, units.
REQ-018 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; units always shown.
REQ-019 While DVZ=1, the display SHALL show "Err " (digits 3..1 = E, r, r; digit0 blank), decoded in the same cycle; conversion state SHALL be unaffected.
REQ-020 Before the first capture after reset, all digits SHALL be blank.
REQ-021 Scanning: the free-running REFRESH_BITS counter wraps modulo 2^REFRESH_BITS; its top 2 bits select the digit index; an SHALL be active-low one-hot at that index; seg and an SHALL be registered together (no ghosting skew).
REQ-022 sel_rem SHALL take effect at the next digit refresh with no reconversion.
REQ-023 Segment codes SHALL be: 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000, '-' = 0111111, E = 0000110, r = 0101111, blank = 1111111.

Reset
REQ-024 When rst_n=0 at a clock edge: state IDLE, busy=0, refresh counter 0, BCD and display registers 0, "valid" flag 0, done-history register 0, an=1111, seg=1111111.
REQ-025 Reset mid-conversion SHALL abandon the conversion with no display update; the display is blank afterwards.

Structure
REQ-026 A shared package SHALL hold the FSM state encodings, the internal digit codes (0-9, MINUS=10, E=11, R=12, BLANK=15) and the segment constants.
REQ-027 Sub-module seg7_encode (combinational, 4-bit digit code -> 7-bit seg) SHALL be instantiated once on the muxed digit.

Verification
REQ-028 Reset, then release with no done edge -> an cycles 1110, 1101, 1011, 0111 (REFRESH_BITS=4); seg=1111111 throughout.
REQ-029 quo_mag=123, quo_neg=1, done 0->1, sel_rem=0 -> busy=1 for 17 cycles; then digits "-123": 0111111, 1111001, 0100100, 0110000.
REQ-030 quo_mag=5, quo_neg=0 -> digits 3..1 blank, digit0 = 0010010; quo_mag=0, quo_neg=1 -> only digit0 = 1000000.
REQ-031 After the REQ-029 capture with rem_mag=255, rem_neg=0, set sel_rem=1 -> "255" with no busy pulse.
REQ-032 DVZ=1 -> "Err " immediately; DVZ back to 0 -> the last captured result is restored.
REQ-033 Second done edge 6 cycles into conversion (quo_mag=42) -> restart, "42" shown 17 cycles after the second edge; assert rst_n=0 mid-conversion -> display blank, busy=0.
